// File: rtl/enigma_stream_core.sv
// enigma_stream_core: single-stage streaming Enigma cipher.
// The rotors step on each accepted valid symbol. The symbol then goes through the
// forward rotor chain, the reflector and the backward chain within the same cycle.
// The result lands in a one-deep output register with valid/ready handshaking.
module enigma_stream_core #(
  parameter int SYM_W      = 6,
  parameter int ALPHABET   = 26,
  parameter int NUM_ROTORS = 3,
  parameter int NOTCH      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [NUM_ROTORS*SYM_W-1:0] load_pos,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SYM_W-1:0]            in_sym,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SYM_W-1:0]            out_sym,
  output logic                        out_err,
  output logic [NUM_ROTORS*SYM_W-1:0] pos
);

  // One extra bit so that ALPHABET == 2^SYM_W and sums up to 2*ALPHABET-2 are representable.
  localparam logic [SYM_W:0]   ALPHA_W = (SYM_W+1)'(ALPHABET);
  localparam logic [SYM_W-1:0] AMAX    = SYM_W'(ALPHABET - 1);
  localparam logic [SYM_W-1:0] NOTCH_S = SYM_W'(NOTCH);

  // (a + b) mod ALPHABET for a, b already reduced: a single conditional subtract.
  function automatic logic [SYM_W-1:0] add_mod(input logic [SYM_W-1:0] a,
                                                input logic [SYM_W-1:0] b);
    logic [SYM_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= ALPHA_W) s = s - ALPHA_W;
    return s[SYM_W-1:0];
  endfunction

  // (a - b) mod ALPHABET for a, b already reduced: a single conditional add.
  function automatic logic [SYM_W-1:0] sub_mod(input logic [SYM_W-1:0] a,
                                                input logic [SYM_W-1:0] b);
    logic [SYM_W:0] s;
    if (a < b) s = {1'b0, a} + ALPHA_W - {1'b0, b};
    else       s = {1'b0, a} - {1'b0, b};
    return s[SYM_W-1:0];
  endfunction

  // Rotor advance with wrap from ALPHABET-1 back to 0.
  function automatic logic [SYM_W-1:0] inc_mod(input logic [SYM_W-1:0] a);
    return (a == AMAX) ? '0 : a + 1'b1;
  endfunction

  logic [SYM_W-1:0]      pos_p1 [NUM_ROTORS];
  logic                  vld_p1;
  logic [SYM_W-1:0]      out_sym_p1;
  logic                  out_err_p1;

  logic [NUM_ROTORS-1:0] step_p0;
  logic [SYM_W-1:0]      qpos_p0 [NUM_ROTORS];
  logic [SYM_W-1:0]      ld_p0   [NUM_ROTORS];
  logic [SYM_W-1:0]      fwd_p0;
  logic [SYM_W-1:0]      refl_p0;
  logic [SYM_W-1:0]      bwd_p0;
  logic                  sym_ok_p0;
  logic                  accept_p0;

  // ---- stage p0: handshake, stepping and combinational cipher path ----

  // Load never coincides with an accept; the output slot frees up when it is being drained.
  assign in_ready  = !load && (!vld_p1 || out_ready);
  assign accept_p0 = in_valid && in_ready;
  assign sym_ok_p0 = ({1'b0, in_sym} < ALPHA_W);

  // Step decisions from pre-step positions, including the middle-rotor double-step.
  always_comb begin
    step_p0    = '0;
    step_p0[0] = 1'b1;
    for (int k = 1; k < NUM_ROTORS; k++) begin
      step_p0[k] = (pos_p1[k-1] == NOTCH_S) ||
                   ((k <= NUM_ROTORS - 2) && (pos_p1[k] == NOTCH_S));
    end
    for (int k = 0; k < NUM_ROTORS; k++) begin
      qpos_p0[k] = step_p0[k] ? inc_mod(pos_p1[k]) : pos_p1[k];
    end
  end

  // Load values, with out-of-alphabet fields forced to position 0.
  always_comb begin
    for (int k = 0; k < NUM_ROTORS; k++) begin
      ld_p0[k] = ({1'b0, load_pos[k*SYM_W +: SYM_W]} < ALPHA_W) ?
                 load_pos[k*SYM_W +: SYM_W] : '0;
    end
  end

  // Forward chain, reflector (mirror about the alphabet centre), then backward chain.
  always_comb begin
    fwd_p0 = in_sym;
    for (int k = 0; k < NUM_ROTORS; k++) begin
      fwd_p0 = add_mod(fwd_p0, qpos_p0[k]);
    end
    refl_p0 = AMAX - fwd_p0;
    bwd_p0  = refl_p0;
    for (int k = NUM_ROTORS - 1; k >= 0; k--) begin
      bwd_p0 = sub_mod(bwd_p0, qpos_p0[k]);
    end
  end

  // ---- stage p1: rotor position and output registers ----

  // Rotor positions: reset to zero, load from load_pos, step only on a valid-symbol accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_ROTORS; k++) pos_p1[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < NUM_ROTORS; k++) pos_p1[k] <= ld_p0[k];
    end else if (accept_p0 && sym_ok_p0) begin
      for (int k = 0; k < NUM_ROTORS; k++) pos_p1[k] <= qpos_p0[k];
    end
  end

  // Output slot: filled on accept, emptied on consume; invalid symbols pass through flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      out_sym_p1 <= '0;
      out_err_p1 <= 1'b0;
    end else if (accept_p0) begin
      vld_p1     <= 1'b1;
      out_sym_p1 <= sym_ok_p0 ? bwd_p0 : in_sym;
      out_err_p1 <= !sym_ok_p0;
    end else if (vld_p1 && out_ready) begin
      vld_p1     <= 1'b0;
    end
  end

  // Pack rotor positions onto the flat port.
  always_comb begin
    pos = '0;
    for (int k = 0; k < NUM_ROTORS; k++) pos[k*SYM_W +: SYM_W] = pos_p1[k];
  end

  assign out_valid = vld_p1;
  assign out_sym   = out_sym_p1;
  assign out_err   = out_err_p1;

endmodule
